// File: rtl/dff_check_pkg.sv
// rtl/dff_check_pkg.sv - shared types and helpers for the dff response checker
package dff_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int SAT_W = 64;

    // Saturating increment of a w-bit counter carried in a SAT_W-bit container.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                                 input int unsigned w);
        logic [SAT_W-1:0] max_v;
        max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (cnt >= max_v) ? max_v : cnt + SAT_W'(1);
    endfunction

endpackage

// File: rtl/dff_response_checker.sv
// rtl/dff_response_checker.sv - compares a dff DUT's q/qb against a one-cycle-delayed model
module dff_response_checker
    import dff_check_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               CNT_W         = 16,
    parameter int               TS_W          = 32,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter bit               DUT_ASYNC_RST = 1'b0,
    parameter int               MIN_CHECKS    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             dut_rst,
    input  logic [WIDTH-1:0] dut_d,
    input  logic [WIDTH-1:0] dut_q,
    input  logic [WIDTH-1:0] dut_qb,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic             first_err_valid,
    output logic [TS_W-1:0]  first_err_cycle,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic             pass
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] exp_q;
    logic             exp_valid;
    logic [TS_W-1:0]  cycle;
    logic             do_check;
    logic             mismatch;
    logic [WIDTH-1:0] cmp_exp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // exp_valid marks that exp_q was captured on the immediately preceding edge;
    // a disabled edge leaves the history stale, so the next enabled edge only re-primes.
    always_comb begin
        state_nxt = state;
        do_check  = 1'b0;
        cmp_exp   = exp_q;
        mismatch  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else if (enable) begin
            case (state)
                IDLE: state_nxt = ARMED;
                ARMED, CHECK: begin
                    state_nxt = CHECK;
                    do_check  = exp_valid;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            state_nxt = ARMED;
        end
        if (DUT_ASYNC_RST && dut_rst) begin
            cmp_exp = RESET_VAL;
        end
        mismatch = do_check && ((dut_q != cmp_exp) || (dut_qb != ~dut_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle           <= '0;
            exp_q           <= '0;
            exp_valid       <= 1'b0;
            err_pulse       <= 1'b0;
            err_count       <= '0;
            check_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_cycle <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else begin
            cycle <= cycle + TS_W'(1);
            if (clear) begin
                exp_q           <= '0;
                exp_valid       <= 1'b0;
                err_pulse       <= 1'b0;
                err_count       <= '0;
                check_count     <= '0;
                first_err_valid <= 1'b0;
                first_err_cycle <= '0;
                first_err_exp   <= '0;
                first_err_got   <= '0;
            end else begin
                err_pulse <= mismatch;
                if (enable) begin
                    exp_q     <= dut_rst ? RESET_VAL : dut_d;
                    exp_valid <= 1'b1;
                end else begin
                    exp_valid <= 1'b0;
                end
                if (do_check) begin
                    check_count <= CNT_W'(sat_inc(SAT_W'(check_count), CNT_W));
                end
                if (mismatch) begin
                    err_count <= CNT_W'(sat_inc(SAT_W'(err_count), CNT_W));
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_cycle <= cycle;
                        first_err_exp   <= cmp_exp;
                        first_err_got   <= dut_q;
                    end
                end
            end
        end
    end

    assign pass = (int'(check_count) >= MIN_CHECKS) && (err_count == '0);

endmodule

// File: tb/tb_dff_response_checker.sv
// tb/tb_dff_response_checker.sv - self-checking bench for dff_response_checker
module tb_dff_response_checker;

    localparam logic RV = 1'b0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       clear;
    logic       dut_rst;
    logic [0:0] dut_d;
    logic [0:0] dut_q;
    logic [0:0] dut_qb;
    logic [0:0] ideal_q;
    logic [1:0] fault_mode;

    logic        m_pulse_o, m_fv_o, m_pass_o;
    logic [15:0] m_ec_o, m_cc_o;
    logic [31:0] m_fcyc_o;
    logic [0:0]  m_fexp_o, m_fgot_o;
    logic        s_pulse_o, s_fv_o, s_pass_o;
    logic [2:0]  s_ec_o, s_cc_o;
    logic [31:0] s_fcyc_o;
    logic [0:0]  s_fexp_o, s_fgot_o;

    always #5 clk = ~clk;

    // Ideal flip-flop plus injectable output faults:
    // 0 ideal, 1 q stuck at 0, 2 qb tied to q, 3 q inverted.
    always @(posedge clk) ideal_q <= dut_rst ? RV : dut_d;
    assign dut_q  = (fault_mode == 2'd1) ? 1'b0 : (fault_mode == 2'd3) ? ~ideal_q : ideal_q;
    assign dut_qb = (fault_mode == 2'd2) ? dut_q : ~dut_q;

    dff_response_checker #(.WIDTH(1), .CNT_W(16), .TS_W(32), .RESET_VAL(RV),
                           .DUT_ASYNC_RST(1'b0), .MIN_CHECKS(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .dut_rst(dut_rst), .dut_d(dut_d), .dut_q(dut_q), .dut_qb(dut_qb),
        .err_pulse(m_pulse_o), .err_count(m_ec_o), .check_count(m_cc_o),
        .first_err_valid(m_fv_o), .first_err_cycle(m_fcyc_o),
        .first_err_exp(m_fexp_o), .first_err_got(m_fgot_o), .pass(m_pass_o)
    );

    dff_response_checker #(.WIDTH(1), .CNT_W(3), .TS_W(32), .RESET_VAL(RV),
                           .DUT_ASYNC_RST(1'b0), .MIN_CHECKS(4)) u_small (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .dut_rst(dut_rst), .dut_d(dut_d), .dut_q(dut_q), .dut_qb(dut_qb),
        .err_pulse(s_pulse_o), .err_count(s_ec_o), .check_count(s_cc_o),
        .first_err_valid(s_fv_o), .first_err_cycle(s_fcyc_o),
        .first_err_exp(s_fexp_o), .first_err_got(s_fgot_o), .pass(s_pass_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a comparison happens on an enabled edge whose previous
    // edge was also enabled (since reset/clear); expected q is what that edge sampled.
    int          m_cc, m_ec;
    bit          m_prev_ok, m_pulse, m_fv;
    logic        m_prev_exp, m_fexp, m_fgot;
    logic [31:0] m_stamp, m_fcyc;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_cc = 0; m_ec = 0; m_prev_ok = 0; m_pulse = 0; m_fv = 0;
        m_prev_exp = 0; m_fexp = 0; m_fgot = 0; m_stamp = 0; m_fcyc = 0;
    endtask

    task automatic model_edge(input bit en, input bit clr, input bit rst, input bit d);
        bit   mm;
        logic e;
        mm = 0;
        if (clr) begin
            m_cc = 0; m_ec = 0; m_prev_ok = 0; m_fv = 0;
            m_prev_exp = 0; m_fexp = 0; m_fgot = 0; m_fcyc = 0;
        end else begin
            if (en && m_prev_ok) begin
                e = m_prev_exp;
                m_cc++;
                mm = (dut_q[0] != e) || (dut_qb[0] != ~dut_q[0]);
                if (mm) begin
                    m_ec++;
                    if (!m_fv) begin
                        m_fv = 1; m_fcyc = m_stamp; m_fexp = e; m_fgot = dut_q[0];
                    end
                end
            end
            m_prev_ok = en;
            if (en) m_prev_exp = rst ? RV : d;
        end
        m_pulse = mm;
        m_stamp++;
    endtask

    task automatic compare_all();
        chk("err_pulse", m_pulse_o, m_pulse);
        chk("check_count", m_cc_o, sat(m_cc, 65535));
        chk("err_count", m_ec_o, sat(m_ec, 65535));
        chk("first_err_valid", m_fv_o, m_fv);
        chk("first_err_cycle", m_fcyc_o, m_fcyc);
        chk("first_err_exp", m_fexp_o, m_fexp);
        chk("first_err_got", m_fgot_o, m_fgot);
        chk("pass", m_pass_o, (m_cc >= 8) && (m_ec == 0));
        chk("small_check_count", s_cc_o, sat(m_cc, 7));
        chk("small_err_count", s_ec_o, sat(m_ec, 7));
        chk("small_err_pulse", s_pulse_o, m_pulse);
        chk("small_pass", s_pass_o, (sat(m_cc, 7) >= 4) && (m_ec == 0));
    endtask

    task automatic step(input bit en, input bit clr, input bit rst, input bit d,
                        input bit [1:0] fault);
        enable = en; clear = clr; dut_rst = rst; dut_d = d; fault_mode = fault;
        #1;
        model_edge(en, clr, rst, d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        bit       en, clr, rst, d;
        bit [1:0] fault;
        int       cc, ec;
        bit       pulse, pass;
    } vec_t;

    function automatic vec_t v(input bit en, input bit clr, input bit rst, input bit d,
                               input bit [1:0] fault, input int cc, input int ec,
                               input bit pulse, input bit pass);
        vec_t r;
        r.en = en; r.clr = clr; r.rst = rst; r.d = d; r.fault = fault;
        r.cc = cc; r.ec = ec; r.pulse = pulse; r.pass = pass;
        return r;
    endfunction

    vec_t        vecs[$];
    logic [31:0] t3_stamp;

    initial begin
        for (int k = 0; k < 10; k++) vecs.push_back(v(1, 0, 0, 1, 0, k, 0, 0, k >= 8));
        for (int k = 10; k < 13; k++) vecs.push_back(v(1, 0, 1, 1, 0, k, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 0, 13, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 0, 14, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 14, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 14, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 0, 14, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 0, 15, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 0, 16, 0, 0, 1));
        vecs.push_back(v(1, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(v(1, 0, 0, 1, 1, k, k, k > 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(v(1, 0, 0, 1, 2, k, k, k > 0, 0));

        reset_n = 0; enable = 0; clear = 0; dut_rst = 0; dut_d = 0; fault_mode = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        reset_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 22) t3_stamp = m_stamp;
            step(vecs[i].en, vecs[i].clr, vecs[i].rst, vecs[i].d, vecs[i].fault);
            chk($sformatf("vec%0d_check_count", i), m_cc_o, vecs[i].cc);
            chk($sformatf("vec%0d_err_count", i), m_ec_o, vecs[i].ec);
            chk($sformatf("vec%0d_err_pulse", i), m_pulse_o, vecs[i].pulse);
            chk($sformatf("vec%0d_pass", i), m_pass_o, vecs[i].pass);
            if (i == 24) begin
                chk("stuck_first_exp", m_fexp_o, 1);
                chk("stuck_first_got", m_fgot_o, 0);
                chk("stuck_first_cycle", m_fcyc_o, t3_stamp);
            end
        end
        chk("qb_first_exp_eq_got", m_fexp_o, m_fgot_o);
        chk("qb_first_valid", m_fv_o, 1);

        for (int i = 0; i < 400; i++) begin
            bit [1:0] f;
            f = ($urandom % 16 == 0) ? 2'd3 : (($urandom % 40 == 0) ? 2'd2 : 2'd0);
            step($urandom % 8 != 0, $urandom % 50 == 0, $urandom % 10 == 0,
                 1'($urandom), f);
        end

        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 1, 1);
        chk("sat_small_err_count", s_ec_o, 7);
        chk("sat_small_check_count", s_cc_o, 7);
        chk("sat_main_err_count", m_ec_o, 10);
        step(0, 1, 0, 1, 1);
        chk("clear_err_count", s_ec_o, 0);
        chk("clear_first_valid", m_fv_o, 0);
        chk("clear_err_pulse", m_pulse_o, 0);
        step(1, 0, 0, 1, 0);
        chk("clear_idle_no_compare", m_cc_o, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 1);

        #2;
        reset_n = 0;
        model_reset();
        #1;
        chk("async_check_count", m_cc_o, 0);
        chk("async_err_count", m_ec_o, 0);
        chk("async_first_valid", m_fv_o, 0);
        chk("async_err_pulse", m_pulse_o, 0);
        chk("async_small_check_count", s_cc_o, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1'($urandom), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
